// File: rtl/mtr_spd_ramp_if.sv
// Speed ramp bus: command/mode inputs from the control loop and the ramped
// speeds back to the motor driver.
//   moving        1 = track commands, 0 = brake to zero
//   e_stop        emergency stop, level-sensitive
//   lft/rght_spd_cmd  raw signed speed commands
//   lft/rght_spd      ramped, clamped signed speeds (registered in the ramp)
//   at_target     outputs have settled
interface mtr_spd_ramp_if;
    localparam int unsigned SPD_W = 11;

    logic                    moving;
    logic                    e_stop;
    logic signed [SPD_W-1:0] lft_spd_cmd;
    logic signed [SPD_W-1:0] rght_spd_cmd;
    logic signed [SPD_W-1:0] lft_spd;
    logic signed [SPD_W-1:0] rght_spd;
    logic                    at_target;

    // Control loop side
    modport master (
        output moving, e_stop, lft_spd_cmd, rght_spd_cmd,
        input  lft_spd, rght_spd, at_target
    );

    // Ramp block side
    modport slave (
        input  moving, e_stop, lft_spd_cmd, rght_spd_cmd,
        output lft_spd, rght_spd, at_target
    );
endinterface

// File: rtl/mtr_spd_ramp.sv
// Slew-rate limiter and saturator ahead of the motor driver.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (zeroes outputs immediately)
//   bus    mtr_spd_ramp_if.slave: moving/e_stop/commands in, ramped speeds
//          and at_target out
// Outputs move only on ramp ticks (every TICK_DIV clocks) by at most STEP
// (running) or BRK_STEP (braking); e_stop zeroes them on the next edge.
module mtr_spd_ramp #(
    parameter int unsigned TICK_DIV = 1024,
    parameter int unsigned STEP     = 8,
    parameter int unsigned BRK_STEP = 32,
    parameter int unsigned MAX_MAG  = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    mtr_spd_ramp_if.slave  bus
);
    localparam int unsigned SPD_W = 11;
    localparam int unsigned DIF_W = SPD_W + 1;
    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    localparam logic signed [DIF_W-1:0] MAG_POS  = DIF_W'(MAX_MAG);
    localparam logic signed [DIF_W-1:0] MAG_NEG  = -MAG_POS;
    localparam logic        [DIF_W-1:0] RUN_STEP = DIF_W'(STEP);
    localparam logic        [DIF_W-1:0] BRK_STP  = DIF_W'(BRK_STEP);
    localparam logic        [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } state_e;

    // Saturate a raw command to +/-MAX_MAG; widened first so -1024 is handled.
    function automatic logic signed [SPD_W-1:0] clamp_cmd(
        input logic signed [SPD_W-1:0] cmd
    );
        logic signed [DIF_W-1:0] cmd_x;
        logic signed [DIF_W-1:0] res;
        cmd_x = $signed({cmd[SPD_W-1], cmd});
        if (cmd_x > MAG_POS) begin
            res = MAG_POS;
        end else if (cmd_x < MAG_NEG) begin
            res = MAG_NEG;
        end else begin
            res = cmd_x;
        end
        return SPD_W'(res);
    endfunction

    // Move cur toward tgt by at most stp; diff is 12-bit so it cannot overflow.
    function automatic logic signed [SPD_W-1:0] step_to(
        input logic signed [SPD_W-1:0] cur,
        input logic signed [SPD_W-1:0] tgt,
        input logic        [DIF_W-1:0] stp
    );
        logic signed [DIF_W-1:0] diff;
        logic        [DIF_W-1:0] mag;
        logic signed [SPD_W-1:0] res;
        diff = $signed({tgt[SPD_W-1], tgt}) - $signed({cur[SPD_W-1], cur});
        mag  = diff[DIF_W-1] ? DIF_W'(-diff) : DIF_W'(diff);
        if (mag <= stp) begin
            res = tgt;
        end else if (diff[DIF_W-1]) begin
            res = cur - $signed(SPD_W'(stp));
        end else begin
            res = cur + $signed(SPD_W'(stp));
        end
        return res;
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [SPD_W-1:0] lft_spd_q, lft_spd_d;
    logic signed [SPD_W-1:0] rght_spd_q, rght_spd_d;
    logic signed [SPD_W-1:0] lft_tgt_c, rght_tgt_c;
    logic                    tick_c;

    assign tick_c     = (cnt_q == CNT_LAST);
    assign lft_tgt_c  = clamp_cmd(bus.lft_spd_cmd);
    assign rght_tgt_c = clamp_cmd(bus.rght_spd_cmd);

    // Next-state, tick counter and ramp step
    always_comb begin
        state_d    = state_q;
        cnt_d      = tick_c ? '0 : cnt_q + CNT_W'(1);
        lft_spd_d  = lft_spd_q;
        rght_spd_d = rght_spd_q;

        if (bus.e_stop) begin
            state_d    = IDLE;
            lft_spd_d  = '0;
            rght_spd_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    lft_spd_d  = '0;
                    rght_spd_d = '0;
                    if (bus.moving) state_d = RUN;
                end
                RUN: begin
                    if (tick_c) begin
                        lft_spd_d  = step_to(lft_spd_q,  lft_tgt_c,  RUN_STEP);
                        rght_spd_d = step_to(rght_spd_q, rght_tgt_c, RUN_STEP);
                    end
                    if (!bus.moving) state_d = BRAKE;
                end
                BRAKE: begin
                    if (tick_c) begin
                        lft_spd_d  = step_to(lft_spd_q,  '0, BRK_STP);
                        rght_spd_d = step_to(rght_spd_q, '0, BRK_STP);
                    end
                    // Leave for IDLE only once both outputs have already reached 0
                    if (bus.moving) begin
                        state_d = RUN;
                    end else if (lft_spd_q == '0 && rght_spd_q == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    lft_spd_d  = '0;
                    rght_spd_d = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lft_spd_q  <= lft_spd_d;
            rght_spd_q <= rght_spd_d;
        end
    end

    assign bus.lft_spd   = lft_spd_q;
    assign bus.rght_spd  = rght_spd_q;
    assign bus.at_target = (state_q == IDLE) ||
                           (state_q == RUN && lft_spd_q == lft_tgt_c &&
                            rght_spd_q == rght_tgt_c);
endmodule

// File: tb/tb_mtr_spd_ramp.sv
// Directed bench for mtr_spd_ramp with TICK_DIV=4, STEP=8, BRK_STEP=32,
// MAX_MAG=1000. Ramp ticks land on every 4th rising edge after reset release.
module tb_mtr_spd_ramp;
    typedef struct {
        logic               mv;
        logic               es;
        logic signed [10:0] lc;
        logic signed [10:0] rc;
        int                 n;
        logic signed [10:0] el;
        logic signed [10:0] er;
        logic               eat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    mtr_spd_ramp_if bus();

    mtr_spd_ramp #(
        .TICK_DIV (4),
        .STEP     (8),
        .BRK_STEP (32),
        .MAX_MAG  (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturation bound must hold on every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (bus.lft_spd > 11'sd1000 || bus.lft_spd < -11'sd1000 ||
                bus.rght_spd > 11'sd1000 || bus.rght_spd < -11'sd1000) begin
                bad++;
                $display("FAIL bound: l=%0d r=%0d exceeds +/-1000", bus.lft_spd, bus.rght_spd);
            end
        end
    end

    task automatic add(input logic mv, input logic es,
                       input int lc, input int rc, input int n,
                       input int el, input int er, input logic eat);
        vec_t v;
        v.mv = mv; v.es = es; v.lc = 11'(lc); v.rc = 11'(rc); v.n = n;
        v.el = 11'(el); v.er = 11'(er); v.eat = eat;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic mv, input logic es,
                         input logic signed [10:0] lc, input logic signed [10:0] rc);
        bus.moving       = mv;
        bus.e_stop       = es;
        bus.lft_spd_cmd  = lc;
        bus.rght_spd_cmd = rc;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic signed [10:0] el,
                         input logic signed [10:0] er, input logic eat);
        total++;
        if (bus.lft_spd !== el || bus.rght_spd !== er || bus.at_target !== eat) begin
            bad++;
            $display("FAIL %s: got l=%0d r=%0d at=%0b, exp l=%0d r=%0d at=%0b",
                     nm, bus.lft_spd, bus.rght_spd, bus.at_target, el, er, eat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 11'sd100, -11'sd50);

        // Ramp up L to 100 / R to -50, no change between ticks
        add(1, 0,  100,   -50,   3,    0,    0, 0);
        add(1, 0,  100,   -50,   1,    8,   -8, 0);
        add(1, 0,  100,   -50,  44,   96,  -50, 0);
        add(1, 0,  100,   -50,   3,   96,  -50, 0);
        add(1, 0,  100,   -50,   1,  100,  -50, 1);
        // Saturation, including -1024
        add(1, 0, 1023, -1024,  16,  132,  -82, 0);
        add(1, 0, 1023, -1024, 480, 1000, -1000, 1);
        // Settle at +/-200 then brake
        add(1, 0,  200,  -200, 440,  200, -200, 1);
        add(0, 0,  200,  -200,   1,  200, -200, 0);
        add(0, 0,  200,  -200,   3,  168, -168, 0);
        add(0, 0,  200,  -200,  20,    8,   -8, 0);
        add(0, 0,  200,  -200,   4,    0,    0, 0);
        add(0, 0,  200,  -200,   1,    0,    0, 1);
        // Reversal 96 -> -96 through zero
        add(1, 0,   96,     0,   3,    8,    0, 0);
        add(1, 0,   96,     0,  44,   96,    0, 1);
        add(1, 0,  -96,     0,  44,    8,    0, 0);
        add(1, 0,  -96,     0,   4,    0,    0, 0);
        add(1, 0,  -96,     0,   4,   -8,    0, 0);
        add(1, 0,  -96,     0,  44,  -96,    0, 1);
        // Mid-ramp e_stop at L=48, hold, then restart from 0
        add(1, 0,  200,     0,  72,   48,    0, 0);
        add(1, 1,  200,     0,   1,    0,    0, 1);
        add(1, 1,  200,     0,   4,    0,    0, 1);
        add(1, 0,  200,     0,   1,    0,    0, 0);
        add(1, 0,  200,     0,   2,    8,    0, 0);
        // Set up a brake in progress for the reset check
        add(1, 0,  200,     0,  40,   88,    0, 0);
        add(0, 0,  200,     0,   1,   88,    0, 0);
        add(0, 0,  200,     0,   3,   56,    0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 11'sd0, 11'sd0, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mv, vecs[i].es, vecs[i].lc, vecs[i].rc);
            edges(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, vecs[i].eat);
        end

        // Asynchronous reset mid-brake, between clock edges
        #2 rst_n = 1'b0;
        #1 check("async_rst", 11'sd0, 11'sd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 11'sd100, -11'sd50);
        rst_n = 1'b1;
        edges(3);
        check("rst_restart_no_tick", 11'sd0, 11'sd0, 1'b0);
        edges(1);
        check("rst_restart_tick4", 11'sd8, -11'sd8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
